alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle shift-and-add multiplier sequencer that drives the shared 16-bit ALU.
- Computes the low 16 bits of a×b by issuing add and double operations to the ALU.
- Holds the accumulator, multiplicand and multiplier registers itself.
- Sits between the CPU-side start/done handshake and the ALU's operand and control inputs; the ALU stays a separate combinational instance.

## Interface
Parameters:
- WIDTH, 16, operand/product width; the ALU is fixed at 16.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only when busy=0
- a  in  16  multiplicand, latched on accepted start
- b  in  16  multiplier, latched on accepted start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; product valid
- product  out  16  result, held until next accepted start
- alu_x, alu_y  out  16  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
- alu_out  in  16  ALU result

## Operation
- States: IDLE, ADD, DBL, DONE. Internal registers: acc, mcand, mplier, and a 4-bit iteration count.
- Idle ALU drive (IDLE/DONE): x=y=0, zx=1, nx=0, zy=1, ny=0, f=1, no=0, so the ALU outputs 0.
- ADD: x=acc, y=mcand, zx=0, nx=0, ny=0, f=1, no=0; acc<=alu_out.
- DBL: x=y=mcand, add control word; mcand<=alu_out; mplier<=mplier>>1.
- Accepted start (in IDLE or DONE): acc<=0, mcand<=a, mplier<=b, count<=0. The next state depends on the configuration.
- Arithmetic is modulo 2^16. Signed and unsigned results are identical in the low 16 bits; there is no overflow flag.
- product<=acc on entry to DONE.
- DONE lasts one cycle with done=1, then returns to IDLE unless a new start is accepted in that cycle.
- start while busy=1 is ignored; a and b are not re-latched.
- Reset at any time: state IDLE; acc, mcand, mplier, count, product = 0; busy=0, done=0.

## Timing
- busy=1 exactly in ADD/DBL states. done=1 exactly in DONE. All outputs are registered or decoded from state only, with no combinational path from start.
- ALU operands and control are decoded from state and registers. The ALU result is captured at the end of the same cycle (single-cycle ALU path).
- Fixed mode:
  - 16 iterations of ADD then DBL.
  - In ADD, zy = ~mplier[0], so acc is unchanged when the bit is clear.
  - After the 16th DBL the FSM enters DONE.
  - done is seen 33 cycles after the accepting edge.

## Configuration
- ALU_MUL_EARLY_EXIT_EN defined: data-dependent latency.
  - On start: b==0 -> DONE; else b[0] ? ADD : DBL.
  - In ADD, zy=0. Next state: mplier[15:1]==0 -> DONE, else DBL.
  - After DBL: new mplier[0] ? ADD : DBL.
  - Done latency = number of ADD and DBL cycles + 1, e.g. b=5 gives 5 cycles.
- ALU_MUL_EARLY_EXIT_EN undefined: fixed 33-cycle latency as above; count is used and ADD is never skipped.

## Structure
- Shared package holds:
  - State encoding (2 bits).
  - 6-bit ALU control-word constants CW_ADD, CW_ADD_ZY, CW_ZERO, ordered {zx,nx,zy,ny,f,no}.
  - The iteration-count terminal value 15.
- One sub-module, alu_mul_seq_ctl, holds the FSM, the iteration counter and the control-word decode. Operand registers stay in the top module.
- The ALU is instantiated outside this block.

## Test plan
- Reset: after reset, busy=0, done=0, product=0, and the ALU control word equals CW_ZERO.
- Small product, a=3, b=5: product=15.
  - Fixed mode: done 33 cycles after the start edge.
  - With EN: done 5 cycles after, via the sequence ADD,DBL,DBL,ADD.
- Wrap and signed, a=0x0100, b=0x0100 -> product=0x0000. a=0xFFFD (−3), b=7 -> product=0xFFEB.
- Zero multiplier, b=0:
  - With EN: done 1 cycle after start, product=0.
  - Fixed mode: product=0 after 33 cycles.
- Start while busy is ignored and the first result is unaffected:
  - First start a=6, b=7.
  - Second start a=9, b=9 pulsed mid-operation.
  - Response: product=42.
- Reset mid-operation, then start a=2, b=3:
  - Reset asserted at cycle 10 clears state; busy=0 and no done pulse.
  - Subsequent start a=2, b=3 yields product=6.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: state encoding, ALU control words and iteration limit shared by the multiplier sequencer.
package alu_mul_seq_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_DBL = 2'd2, S_DONE = 2'd3} state_e;
  // Control words ordered {zx,nx,zy,ny,f,no}
  localparam logic [5:0] CW_ADD    = 6'b000010;
  localparam logic [5:0] CW_ADD_ZY = 6'b001010;
  localparam logic [5:0] CW_ZERO   = 6'b101010;
  localparam logic [3:0] CNT_LAST  = 4'd15;
endpackage

// File: rtl/alu_mul_seq_ctl.sv
// alu_mul_seq_ctl: sequencer FSM, iteration counter and ALU control-word decode.
// ALU_MUL_EARLY_EXIT_EN selects data-dependent latency; otherwise a fixed 16-iteration schedule.
module alu_mul_seq_ctl
  import alu_mul_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
`ifdef ALU_MUL_EARLY_EXIT_EN
  input  logic       b_zero,
  input  logic       b_lsb,
  input  logic       mplier_hi_zero,
  input  logic       mplier_next_lsb,
`else
  input  logic       mplier_lsb,
`endif
  output state_e     state,
  output logic       accept,
  output logic       finish,
  output logic       busy,
  output logic       done,
  output logic [5:0] cw
);
  state_e state_q, state_d;
  logic   busy_q, done_q;
`ifdef ALU_MUL_EARLY_EXIT_EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ADD:   state_d = mplier_hi_zero ? S_DONE : S_DBL;
      S_DBL:   state_d = mplier_next_lsb ? S_ADD : S_DBL;
      default: state_d = !start ? S_IDLE : b_zero ? S_DONE : b_lsb ? S_ADD : S_DBL;
    endcase
  end
  assign cw = (state_q == S_ADD || state_q == S_DBL) ? CW_ADD : CW_ZERO;
`else
  logic [3:0] count_q, count_d;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_ADD:   state_d = S_DBL;
      S_DBL: begin
        state_d = (count_q == CNT_LAST) ? S_DONE : S_ADD;
        count_d = count_q + 4'd1;
      end
      default: begin
        state_d = start ? S_ADD : S_IDLE;
        count_d = start ? 4'd0 : count_q;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  // A clear multiplier bit zeroes y so the add leaves acc unchanged
  assign cw = (state_q == S_ADD) ? (mplier_lsb ? CW_ADD : CW_ADD_ZY) :
              (state_q == S_DBL) ? CW_ADD : CW_ZERO;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_ADD) || (state_d == S_DBL);
      done_q  <= state_d == S_DONE;
    end
  assign state  = state_q;
  assign accept = start && !busy_q;
  assign finish = state_d == S_DONE;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier driving an external 16-bit ALU; low WIDTH bits of a*b.
// ALU_MUL_EARLY_EXIT_EN enables data-dependent latency.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d;
  state_e     state;
  logic       accept, finish;
  logic [5:0] cw;
  alu_mul_seq_ctl u_ctl (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
`ifdef ALU_MUL_EARLY_EXIT_EN
    .b_zero          (b == '0),
    .b_lsb           (b[0]),
    .mplier_hi_zero  ((mplier_q >> 1) == '0),
    .mplier_next_lsb (mplier_q[1]),
`else
    .mplier_lsb      (mplier_q[0]),
`endif
    .state           (state),
    .accept          (accept),
    .finish          (finish),
    .busy            (busy),
    .done            (done),
    .cw              (cw)
  );
  always_comb begin
    acc_d     = accept ? '0 : (state == S_ADD) ? alu_out : acc_q;
    mcand_d   = accept ? a : (state == S_DBL) ? alu_out : mcand_q;
    mplier_d  = accept ? b : (state == S_DBL) ? mplier_q >> 1 : mplier_q;
    // Capture the freshly updated acc so a final ADD lands in the product
    product_d = finish ? acc_d : product_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  assign alu_x   = (state == S_ADD) ? acc_q : (state == S_DBL) ? mcand_q : '0;
  assign alu_y   = (state == S_ADD || state == S_DBL) ? mcand_q : '0;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = cw;
  assign product = product_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed-vector bench for alu_mul_seq with a behavioural ALU model.
module tb_alu_mul_seq;
`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic        clock = 0, reset = 1, start = 0;
  logic [15:0] a = 0, b = 0, product, alu_x, alu_y, alu_out;
  logic        busy, done, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] x1, x2, y1, y2, r;
  int          checks = 0, errors = 0;

  alu_mul_seq dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out)
  );

  always #5 clock = ~clock;

  always_comb begin
    x1 = alu_zx ? 16'h0 : alu_x;
    x2 = alu_nx ? ~x1 : x1;
    y1 = alu_zy ? 16'h0 : alu_y;
    y2 = alu_ny ? ~y1 : y1;
    r  = alu_f ? x2 + y2 : x2 & y2;
    alu_out = alu_no ? ~r : r;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [15:0] av, input logic [15:0] bv,
                     input logic [15:0] exp_p, input int lat);
    int n = 0;
    @(negedge clock);
    a = av; b = bv; start = 1;
    @(posedge clock);
    #1 start = 0;
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, lat > 1});
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 100);
    check({tag, "_latency"}, n, lat);
    check({tag, "_product"}, {16'b0, product}, {16'b0, exp_p});
    @(negedge clock);
    check({tag, "_pulse"}, {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    int n, pulses;
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_product", {16'b0, product}, 0);
    check("rst_cw", {26'b0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2A);

    run("m3x5", 16'd3, 16'd5, 16'd15, EE ? 5 : 33);
    run("wrap", 16'h0100, 16'h0100, 16'h0000, EE ? 10 : 33);
    run("neg", 16'hFFFD, 16'd7, 16'hFFEB, EE ? 6 : 33);
    run("zero", 16'd5, 16'd0, 16'd0, EE ? 1 : 33);

    // Second start mid-operation must be ignored
    @(negedge clock);
    a = 16'd6; b = 16'd7; start = 1;
    @(posedge clock);
    #1 start = 0;
    repeat (2) @(negedge clock);
    a = 16'd9; b = 16'd9; start = 1;
    @(negedge clock);
    start = 0;
    n = 3;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("ign_latency", n, EE ? 6 : 33);
    check("ign_product", {16'b0, product}, 42);
    @(negedge clock);
    check("ign_idle", {30'b0, done, busy}, 0);

    // Reset mid-operation clears everything and suppresses done
    @(negedge clock);
    a = 16'd2; b = 16'h8001; start = 1;
    @(posedge clock);
    #1 start = 0;
    repeat (9) @(negedge clock);
    check("mid_busy_before", {31'b0, busy}, 1);
    reset = 1;
    #1;
    check("mid_busy", {31'b0, busy}, 0);
    check("mid_done", {31'b0, done}, 0);
    check("mid_product", {16'b0, product}, 0);
    @(negedge clock);
    reset = 0;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) pulses++;
    end
    check("mid_no_done", pulses, 0);
    run("m2x3", 16'd2, 16'd3, 16'd6, EE ? 4 : 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
